abaud_sequencer: RTL and testbench

//  Control unit for the auto-baud measurement datapath (BRG counter + 8-bit BRG register).

---
 rtl/abaud_sequencer_if.sv | 30 +++
 rtl/abaud_sequencer.sv | 150 +++++++++++++++
 tb/tb_abaud_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/abaud_sequencer_if.sv
// Signal bundle between the auto-baud sequencer and its surroundings:
// the UART control register, the RX pin and the BRG measurement datapath.
interface abaud_sequencer_if #(
   parameter int CNT_W = 8
);
   // No valid/ready pairs here. ld_en, abaud_clr and UxRXIF_clr are 1-cycle
   // strobes acted on at the next BRGCLK edge; all other signals are levels.
   logic             ABAUD;
   logic             UxRX;
   logic             UxRXIF_clr;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_rst;
   logic             cnt_en;
   logic             ld_en;
   logic             abaud_clr;
   logic             UxRXIF;
   logic             busy;
   logic             abaud_ovf;
   logic [1:0]       dbg_state;

   modport master (
      input  ABAUD, UxRX, UxRXIF_clr, cnt_val,
      output cnt_rst, cnt_en, ld_en, abaud_clr, UxRXIF, busy, abaud_ovf, dbg_state
   );

   modport slave (
      output ABAUD, UxRX, UxRXIF_clr, cnt_val,
      input  cnt_rst, cnt_en, ld_en, abaud_clr, UxRXIF, busy, abaud_ovf, dbg_state
   );
endinterface

// File: rtl/abaud_sequencer.sv
// Auto-baud control FSM: times the 0x55 sync character between its first and last falling edge.
// Optional counter-overflow abort is enabled by defining ABAUD_TIMEOUT_EN.
module abaud_sequencer #(
   parameter int CNT_W  = 8,
   parameter int N_FALL = 5
) (
   input  logic             BRGCLK,
   input  logic             rst_n,
   abaud_sequencer_if.master seq_if
);
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      MEASURE    = 2'd2,
      LOAD       = 2'd3
   } state_e;

   localparam logic [2:0] LAST_EDGE = 3'(N_FALL - 2);

   state_e     state_q;
   logic [2:0] edge_cnt_q;
   logic       sync1_q, sync2_q, prev_q;
   logic       cnt_rst_q, cnt_en_q, ld_en_q, abaud_clr_q, busy_q, flag_q;
   logic       rx_fall;
   logic       final_fall;
   logic       timeout;
   logic       timeout_hit;

   // Same 3-cycle latency on every edge, so the measured interval is exact.
   always_ff @(posedge BRGCLK or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= seq_if.UxRX;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rx_fall    = prev_q & ~sync2_q;
   assign final_fall = rx_fall && (edge_cnt_q == LAST_EDGE);

`ifdef ABAUD_TIMEOUT_EN
   logic ovf_q;

   assign timeout = &seq_if.cnt_val;

   always_ff @(posedge BRGCLK or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (timeout_hit) begin
         ovf_q <= 1'b1;
      end else if (seq_if.UxRXIF_clr) begin
         ovf_q <= 1'b0;
      end
   end

   assign seq_if.abaud_ovf = ovf_q;
`else
   logic unused_cnt_val;

   assign unused_cnt_val   = ^seq_if.cnt_val;
   assign timeout          = 1'b0;
   assign seq_if.abaud_ovf = 1'b0;
`endif

   // A final fall in the same cycle as a full counter still completes the measurement.
   assign timeout_hit = (state_q == MEASURE) && seq_if.ABAUD && timeout && !final_fall;

   always_ff @(posedge BRGCLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         edge_cnt_q  <= 3'd0;
         cnt_rst_q   <= 1'b1;
         cnt_en_q    <= 1'b0;
         ld_en_q     <= 1'b0;
         abaud_clr_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         ld_en_q     <= 1'b0;
         abaud_clr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (seq_if.ABAUD) begin
                  state_q    <= WAIT_START;
                  edge_cnt_q <= 3'd0;
                  busy_q     <= 1'b1;
               end
            end
            WAIT_START: begin
               if (!seq_if.ABAUD) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (rx_fall) begin
                  state_q   <= MEASURE;
                  cnt_rst_q <= 1'b0;
                  cnt_en_q  <= 1'b1;
               end
            end
            MEASURE: begin
               if (!seq_if.ABAUD || timeout_hit) begin
                  state_q   <= IDLE;
                  cnt_rst_q <= 1'b1;
                  cnt_en_q  <= 1'b0;
                  busy_q    <= 1'b0;
               end else if (final_fall) begin
                  state_q     <= LOAD;
                  cnt_en_q    <= 1'b0;
                  ld_en_q     <= 1'b1;
                  abaud_clr_q <= 1'b1;
               end else if (rx_fall) begin
                  edge_cnt_q <= edge_cnt_q + 3'd1;
               end
            end
            LOAD: begin
               state_q   <= IDLE;
               cnt_rst_q <= 1'b1;
               busy_q    <= 1'b0;
            end
            default: begin
               state_q   <= IDLE;
               cnt_rst_q <= 1'b1;
               cnt_en_q  <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   // Set in LOAD has priority over a software clear in the same cycle.
   always_ff @(posedge BRGCLK or negedge rst_n) begin
      if (!rst_n) begin
         flag_q <= 1'b0;
      end else if (state_q == LOAD) begin
         flag_q <= 1'b1;
      end else if (seq_if.UxRXIF_clr) begin
         flag_q <= 1'b0;
      end
   end

   assign seq_if.cnt_rst   = cnt_rst_q;
   assign seq_if.cnt_en    = cnt_en_q;
   assign seq_if.ld_en     = ld_en_q;
   assign seq_if.abaud_clr = abaud_clr_q;
   assign seq_if.busy      = busy_q;
   assign seq_if.UxRXIF    = flag_q;
   assign seq_if.dbg_state = state_q;
endmodule

// File: tb/tb_abaud_sequencer.sv
// Bench for abaud_sequencer: models the BRG counter/register, sends 0x55 frames, scoreboards loaded values.
module tb_abaud_sequencer;
   logic clk;
   logic rst_n;

   abaud_sequencer_if #(.CNT_W(8)) intf ();

   abaud_sequencer #(.CNT_W(8), .N_FALL(5)) dut (
      .BRGCLK (clk),
      .rst_n  (rst_n),
      .seq_if (intf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRG counter datapath model
   always @(posedge clk) begin
      if (intf.cnt_rst)     intf.cnt_val <= 8'd0;
      else if (intf.cnt_en) intf.cnt_val <= intf.cnt_val + 8'd1;
   end

   int pass_cnt = 0;
   int total_cnt = 0;
   int ld_cnt = 0;
   int clr_cnt = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Value loaded into the BRG register is cnt_val during the ld_en cycle.
   always @(negedge clk) begin
      if (rst_n && intf.ld_en) begin
         ld_cnt++;
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_load: got %0d expected no load", intf.cnt_val);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (intf.cnt_val === e) pass_cnt++;
            else $display("FAIL loaded_value: got %0d expected %0d", intf.cnt_val, e);
         end
      end
      if (rst_n && intf.abaud_clr) clr_cnt++;
   end

   // 0x55 frame, LSB first, one start and one stop bit; optionally drop ABAUD after fall number abort_after.
   task automatic send_sync(input int period, input int abort_after);
      logic [7:0] d;
      logic prev_bit;
      logic bit_v;
      int falls;
      d = 8'h55;
      prev_bit = 1'b1;
      falls = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 0)      bit_v = 1'b0;
         else if (i == 9) bit_v = 1'b1;
         else             bit_v = d[i-1];
         if (prev_bit && !bit_v) falls++;
         intf.UxRX = bit_v;
         for (int j = 0; j < period; j++) begin
            @(negedge clk);
            if (abort_after != 0 && falls == abort_after && !bit_v && prev_bit && j == 4)
               intf.ABAUD = 1'b0;
         end
         prev_bit = bit_v;
      end
   endtask

   task automatic clear_flags();
      intf.UxRXIF_clr = 1'b1;
      @(negedge clk);
      intf.UxRXIF_clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic finish_meas(input string nm, input int ld0, input int clr0,
                              input bit exp_ld, input bit exp_ovf);
      int budget;
      budget = 0;
      if (exp_ld) begin
         while (clr_cnt == clr0 && budget < 200) begin
            @(negedge clk);
            budget++;
         end
      end else begin
         repeat (5) @(negedge clk);
      end
      intf.ABAUD = 1'b0;
      repeat (3) @(negedge clk);
      check({nm, "_ld_pulses"}, ld_cnt - ld0, exp_ld ? 1 : 0);
      check({nm, "_abaud_clr_pulses"}, clr_cnt - clr0, exp_ld ? 1 : 0);
      check({nm, "_UxRXIF"}, intf.UxRXIF, exp_ld);
      check({nm, "_abaud_ovf"}, intf.abaud_ovf, exp_ovf);
      check({nm, "_busy_after"}, intf.busy, 0);
      check({nm, "_cnt_rst_after"}, intf.cnt_rst, 1);
      clear_flags();
      check({nm, "_flag_cleared"}, {intf.UxRXIF, intf.abaud_ovf}, 0);
   endtask

   task automatic run_meas(input string nm, input int period, input int abort_after,
                           input bit exp_ld, input logic [7:0] exp_val, input bit exp_ovf);
      int ld0, clr0;
      ld0 = ld_cnt;
      clr0 = clr_cnt;
      intf.ABAUD = 1'b1;
      repeat (3) @(negedge clk);
      if (exp_ld) exp_q.push_back(exp_val);
      send_sync(period, abort_after);
      finish_meas(nm, ld0, clr0, exp_ld, exp_ovf);
   endtask

   typedef struct {
      string      nm;
      int         period;
      int         abort_after;
      bit         exp_ld;
      logic [7:0] exp_val;
      bit         exp_ovf;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int rp;
      int ld0, clr0;
      int budget;

      rp = $urandom_range(9, 31);
      vecs[0] = '{"nominal_10", 10, 0, 1'b1, 8'(8 * 10), 1'b0};
      vecs[1] = '{"abort_3rd_fall", 10, 3, 1'b0, 8'd0, 1'b0};
      vecs[2] = '{"period_12", 12, 0, 1'b1, 8'(8 * 12), 1'b0};
`ifdef ABAUD_TIMEOUT_EN
      vecs[3] = '{"overflow_40", 40, 0, 1'b0, 8'd0, 1'b1};
`else
      vecs[3] = '{"wrap_40", 40, 0, 1'b1, 8'(8 * 40), 1'b0};
`endif
      vecs[4] = '{"period_16", 16, 0, 1'b1, 8'(8 * 16), 1'b0};
      vecs[5] = '{"random_period", rp, 0, 1'b1, 8'(8 * rp), 1'b0};

      rst_n = 1'b0;
      intf.ABAUD = 1'b0;
      intf.UxRX = 1'b1;
      intf.UxRXIF_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {intf.cnt_rst, intf.cnt_en, intf.ld_en, intf.abaud_clr, intf.UxRXIF, intf.busy, intf.abaud_ovf},
            7'b1000000);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 6; i++)
         run_meas(vecs[i].nm, vecs[i].period, vecs[i].abort_after,
                  vecs[i].exp_ld, vecs[i].exp_val, vecs[i].exp_ovf);

      // Clear pulse coinciding with LOAD must lose to the set.
      ld0 = ld_cnt;
      clr0 = clr_cnt;
      intf.ABAUD = 1'b1;
      repeat (3) @(negedge clk);
      exp_q.push_back(8'd80);
      fork
         send_sync(10, 0);
         begin
            budget = 0;
            while (!intf.ld_en && budget < 200) begin
               @(negedge clk);
               budget++;
            end
            check("race_ld_seen", budget < 200, 1);
            intf.UxRXIF_clr = 1'b1;
            @(negedge clk);
            intf.UxRXIF_clr = 1'b0;
            check("race_set_wins", intf.UxRXIF, 1);
            @(negedge clk);
            intf.UxRXIF_clr = 1'b1;
            @(negedge clk);
            intf.UxRXIF_clr = 1'b0;
            check("race_late_clear", intf.UxRXIF, 0);
         end
      join
      intf.ABAUD = 1'b0;
      repeat (3) @(negedge clk);
      check("race_ld_pulses", ld_cnt - ld0, 1);

      // Reset in the middle of a measurement, with UxRXIF left set beforehand.
      intf.ABAUD = 1'b1;
      repeat (3) @(negedge clk);
      exp_q.push_back(8'd80);
      send_sync(10, 0);
      intf.ABAUD = 1'b1;
      repeat (3) @(negedge clk);
      intf.UxRX = 1'b0;
      repeat (16) @(negedge clk);
      intf.UxRX = 1'b1;
      repeat (16) @(negedge clk);
      intf.UxRX = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_reset_measuring", {intf.cnt_en, intf.UxRXIF}, 2'b11);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {intf.cnt_rst, intf.cnt_en, intf.ld_en, intf.abaud_clr, intf.UxRXIF, intf.busy, intf.abaud_ovf},
            7'b1000000);
      intf.ABAUD = 1'b0;
      intf.UxRX = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      run_meas("after_reset_16", 16, 0, 1'b1, 8'd128, 1'b0);

      // Line idle low when armed: no start until a high-then-low transition.
      intf.UxRX = 1'b0;
      repeat (10) @(negedge clk);
      intf.ABAUD = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_low_waiting", {intf.busy, intf.cnt_rst, intf.cnt_en}, 3'b110);
      intf.UxRX = 1'b1;
      repeat (10) @(negedge clk);
      run_meas("idle_low_then_frame", 10, 0, 1'b1, 8'd80, 1'b0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
